// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one AXI transaction out, one response back.
// Optional wait-state timeout (DECERR response) is enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_W-1:0]     ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_W-1:0]     RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 1 || (DATA_W % 8) != 0) begin : g_param_check
    $error("axi4_lite_master: TIMEOUT_CYCLES must be >= 1 and DATA_W a multiple of 8");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_AW_W = 3'd1,
    S_WR_B    = 3'd2,
    S_RD_AR   = 3'd3,
    S_RD_R    = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] awaddr_d, araddr_d;
  logic [DATA_W-1:0] wdata_d, rsp_rdata_d;
  logic [STRB_W-1:0] wstrb_d;
  logic [1:0]        rsp_resp_d;
  logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d;

  // Gated by reset so no command can be accepted while ARESETN is low.
  assign cmd_ready = ARESETN && (state == S_IDLE);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] tmo_cnt;
  logic            in_wait;

  assign in_wait = (state == S_WR_AW_W) || (state == S_WR_B) ||
                   (state == S_RD_AR)   || (state == S_RD_R);

  // Clears on every state change, so each wait state starts from zero.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tmo_cnt <= '0;
    end else if (state_d != state) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TO_LAST) begin
      tmo_cnt <= tmo_cnt + TO_W'(1);
    end
  end
`endif

  always_comb begin
    state_d     = state;
    awaddr_d    = AWADDR;
    wdata_d     = WDATA;
    wstrb_d     = WSTRB;
    araddr_d    = ARADDR;
    awvalid_d   = AWVALID;
    wvalid_d    = WVALID;
    bready_d    = BREADY;
    arvalid_d   = ARVALID;
    rready_d    = RREADY;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_AW_W;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_AR;
          end
        end
      end

      // AW and W retire independently; B is only accepted once both are gone.
      S_WR_AW_W: begin
        if (AWVALID && AWREADY) awvalid_d = 1'b0;
        if (WVALID && WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end

      S_WR_B: begin
        if (BVALID && BREADY) begin
          bready_d    = 1'b0;
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end

      S_RD_AR: begin
        if (ARVALID && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end

      S_RD_R: begin
        if (RVALID && RREADY) begin
          rready_d    = 1'b0;
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    // A handshake completing on the last allowed cycle still wins over the timeout.
    if (in_wait && (state_d == state) && (tmo_cnt == TO_LAST)) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_resp_d  = 2'b11;
      rsp_rdata_d = '0;
      rsp_valid_d = 1'b1;
      state_d     = S_RSP;
    end
`endif
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      AWADDR    <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
      ARADDR    <= '0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      state     <= state_d;
      AWADDR    <= awaddr_d;
      WDATA     <= wdata_d;
      WSTRB     <= wstrb_d;
      ARADDR    <= araddr_d;
      AWVALID   <= awvalid_d;
      WVALID    <= wvalid_d;
      BREADY    <= bready_d;
      ARVALID   <= arvalid_d;
      RREADY    <= rready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp  <= rsp_resp_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: delay-configurable AXI slave, protocol monitor and a memory reference model.
// Adds a timeout scenario when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  int total = 0;
  int bad   = 0;

  int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_arv_cyc = 0;
  bit mon_en = 1'b1;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  // Reference: byte-masked merge of each accepted write.
  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m, old;
    m   = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    old = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    ref_mem[a] = (old & ~m) | (d & m);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Slave model: decisions made 1 time unit after each rising edge.
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit have_aw, have_w, have_ar, b_hs, r_hs;
    logic [31:0] s_awaddr, s_wdata, s_araddr, tmp;
    logic [3:0]  s_wstrb;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    have_aw = 0; have_w = 0; have_ar = 0; b_hs = 0; r_hs = 0;
    s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0;
    forever begin
      @(posedge ACLK); #1;
      if (!ARESETN) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        have_aw = 0; have_w = 0; have_ar = 0; b_hs = 0; r_hs = 0;
      end else begin
        if (AWREADY) begin AWREADY = 0; have_aw = 1; end
        if (WREADY)  begin WREADY = 0;  have_w = 1;  end
        if (ARREADY) begin ARREADY = 0; have_ar = 1; end
        if (b_hs) begin BVALID = 0; b_hs = 0; end
        if (r_hs) begin RVALID = 0; r_hs = 0; end
        if (AWVALID && !have_aw) begin
          if (aw_cnt >= cfg_aw_dly) begin AWREADY = 1; s_awaddr = AWADDR; aw_cnt = 0; end
          else aw_cnt++;
        end else aw_cnt = 0;
        if (WVALID && !have_w) begin
          if (w_cnt >= cfg_w_dly) begin WREADY = 1; s_wdata = WDATA; s_wstrb = WSTRB; w_cnt = 0; end
          else w_cnt++;
        end else w_cnt = 0;
        if (have_aw && have_w && !BVALID) begin
          if (b_cnt >= cfg_b_dly) begin
            tmp = slv_mem.exists(s_awaddr) ? slv_mem[s_awaddr] : 32'h0;
            for (int i = 0; i < 4; i++) if (s_wstrb[i]) tmp[8*i +: 8] = s_wdata[8*i +: 8];
            slv_mem[s_awaddr] = tmp;
            BVALID = 1; BRESP = cfg_bresp; have_aw = 0; have_w = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (BVALID && BREADY) b_hs = 1;
        if (ARVALID && !have_ar) begin
          if (ar_cnt >= cfg_ar_dly) begin ARREADY = 1; s_araddr = ARADDR; ar_cnt = 0; end
          else ar_cnt++;
        end else ar_cnt = 0;
        if (have_ar && !RVALID) begin
          if (r_cnt >= cfg_r_dly) begin
            RDATA = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : 32'h0;
            RRESP = cfg_rresp; RVALID = 1; have_ar = 0; r_cnt = 0;
          end else r_cnt++;
        end
        if (RVALID && RREADY) r_hs = 1;
      end
    end
  end

  // Monitor on the falling edge: handshake counts and VALID/payload stability.
  initial begin
    logic p_rstn, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0] p_wstrb;
    p_rstn = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
    forever begin
      @(negedge ACLK);
      if (ARESETN) begin
        if (AWVALID && AWREADY) n_aw++;
        if (WVALID && WREADY)   n_w++;
        if (BVALID && BREADY)   n_b++;
        if (ARVALID && ARREADY) n_ar++;
        if (RVALID && RREADY)   n_r++;
        if (ARVALID)            n_arv_cyc++;
      end
      if (mon_en && ARESETN && p_rstn) begin
        if (p_awv && !p_awr) begin
          total++;
          if (AWVALID !== 1'b1 || AWADDR !== p_awaddr) begin
            bad++;
            $display("FAIL aw_stable: AWVALID=%b AWADDR=%h required 1/%h", AWVALID, AWADDR, p_awaddr);
          end
        end
        if (p_wv && !p_wr) begin
          total++;
          if (WVALID !== 1'b1 || WDATA !== p_wdata || WSTRB !== p_wstrb) begin
            bad++;
            $display("FAIL w_stable: WVALID=%b WDATA=%h WSTRB=%h required 1/%h/%h", WVALID, WDATA, WSTRB, p_wdata, p_wstrb);
          end
        end
        if (p_arv && !p_arr) begin
          total++;
          if (ARVALID !== 1'b1 || ARADDR !== p_araddr) begin
            bad++;
            $display("FAIL ar_stable: ARVALID=%b ARADDR=%h required 1/%h", ARVALID, ARADDR, p_araddr);
          end
        end
      end
      p_rstn = ARESETN; p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
      p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
      p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
    end
  end

  // Command driver; called and returns 1 time unit after a rising edge.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int hold, output logic [31:0] rd, output logic [1:0] rr,
                       output int lat, output int acc_wait, output bit hold_ok, output bit to);
    to = 0; hold_ok = 1; lat = 0; acc_wait = 0; rd = 32'h0; rr = 2'b00;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    forever begin
      @(negedge ACLK);
      if (cmd_ready) break;
      acc_wait++;
      if (acc_wait > 100) begin to = 1; break; end
    end
    @(posedge ACLK); #1;
    cmd_valid = 0;
    if (to) return;
    lat = 1;
    while (!rsp_valid && lat < 500) begin @(posedge ACLK); #1; lat++; end
    if (!rsp_valid) begin to = 1; return; end
    rd = rsp_rdata; rr = rsp_resp;
    if (hold > 0) begin
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h3C; cmd_wdata = 32'hDEAD0000; cmd_wstrb = 4'hF;
    end
    repeat (hold) begin
      @(posedge ACLK); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rr || cmd_ready !== 1'b0) hold_ok = 0;
    end
    rsp_ready = 1; cmd_valid = 0;
    @(posedge ACLK); #1;
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    logic [140:0] obs;
    ARESETN = 0; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    rsp_ready = 0;
    repeat (3) @(posedge ACLK); #1;
    obs = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, AWADDR, AWVALID, WDATA, WSTRB, WVALID,
           BREADY, ARADDR, ARVALID, RREADY};
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs: got %h required 0", obs); end
    cmd_valid = 0;
    @(negedge ACLK); ARESETN = 1;
    @(posedge ACLK); #1;
    total++;
    if (cmd_ready !== 1'b1 || BREADY !== 1'b0 || RREADY !== 1'b0) begin
      bad++; $display("FAIL reset_release: cmd_ready=%b BREADY=%b RREADY=%b required 1/0/0", cmd_ready, BREADY, RREADY);
    end
  endtask

  task automatic test_write_basic();
    logic [31:0] rd; logic [1:0] rr; int lat, aw, b0, w0, bb0; bit hok, to;
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_bresp = 2'b00;
    b0 = n_aw; w0 = n_w; bb0 = n_b;
    issue(1, 32'h0, 32'hCAFEBABE, 4'hF, 0, rd, rr, lat, aw, hok, to);
    ref_write(32'h0, 32'hCAFEBABE, 4'hF);
    total++; if (to) begin bad++; $display("FAIL wr_basic_timeout: no response, required one"); end
    total++; if (rr !== 2'b00) begin bad++; $display("FAIL wr_basic_resp: got %b required 00", rr); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_basic_rdata: got %h required 0", rd); end
    total++; if (lat !== 3) begin bad++; $display("FAIL wr_basic_latency: got %0d required 3", lat); end
    total++;
    if (n_aw - b0 !== 1 || n_w - w0 !== 1 || n_b - bb0 !== 1) begin
      bad++; $display("FAIL wr_basic_handshakes: aw=%0d w=%0d b=%0d required 1/1/1", n_aw - b0, n_w - w0, n_b - bb0);
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] rd; logic [1:0] rr; int lat, aw, a0, r0; bit hok, to;
    cfg_ar_dly = 2; cfg_r_dly = 0; cfg_rresp = 2'b00;
    a0 = n_ar; r0 = n_r;
    issue(0, 32'h0, 32'h0, 4'h0, 0, rd, rr, lat, aw, hok, to);
    cfg_ar_dly = 0;
    total++; if (to) begin bad++; $display("FAIL rd_basic_timeout: no response, required one"); end
    total++; if (rd !== 32'hCAFEBABE) begin bad++; $display("FAIL rd_basic_rdata: got %h required cafebabe", rd); end
    total++; if (rr !== 2'b00) begin bad++; $display("FAIL rd_basic_resp: got %b required 00", rr); end
    total++; if (lat !== 5) begin bad++; $display("FAIL rd_basic_latency: got %0d required 5", lat); end
    total++;
    if (n_ar - a0 !== 1 || n_r - r0 !== 1) begin
      bad++; $display("FAIL rd_basic_handshakes: ar=%0d r=%0d required 1/1", n_ar - a0, n_r - r0);
    end
  endtask

  task automatic test_write_order();
    int awd [3] = '{0, 3, 2};
    int wd  [3] = '{3, 0, 2};
    logic [31:0] rd, a, d; logic [1:0] rr, br; int lat, aw, b0, w0, bb0, exp_lat; bit hok, to;
    for (int k = 0; k < 3; k++) begin
      cfg_aw_dly = awd[k]; cfg_w_dly = wd[k]; cfg_b_dly = k;
      br = 2'($urandom_range(0, 3)); cfg_bresp = br;
      a = 32'h20 + 32'(4 * k); d = $urandom;
      exp_lat = 3 + ((awd[k] > wd[k]) ? awd[k] : wd[k]) + k;
      b0 = n_aw; w0 = n_w; bb0 = n_b;
      issue(1, a, d, 4'hF, 0, rd, rr, lat, aw, hok, to);
      ref_write(a, d, 4'hF);
      total++; if (to || rr !== br) begin bad++; $display("FAIL wr_order_resp[%0d]: got %b required %b", k, rr, br); end
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL wr_order_latency[%0d]: got %0d required %0d", k, lat, exp_lat); end
      total++;
      if (n_aw - b0 !== 1 || n_w - w0 !== 1 || n_b - bb0 !== 1) begin
        bad++; $display("FAIL wr_order_handshakes[%0d]: aw=%0d w=%0d b=%0d required 1/1/1", k, n_aw - b0, n_w - w0, n_b - bb0);
      end
    end
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_bresp = 2'b00;
  endtask

  task automatic test_rsp_backpressure();
    logic [31:0] rd; logic [1:0] rr; int lat, aw, aw0, ar0; bit hok, to;
    aw0 = n_aw; ar0 = n_ar;
    issue(0, 32'h24, 32'h0, 4'h0, 5, rd, rr, lat, aw, hok, to);
    total++; if (to || !hok) begin bad++; $display("FAIL bp_hold: stable=%b timeout=%b required 1/0", hok, to); end
    total++; if (rd !== ref_read(32'h24)) begin bad++; $display("FAIL bp_rdata: got %h required %h", rd, ref_read(32'h24)); end
    total++;
    if (n_aw - aw0 !== 0 || n_ar - ar0 !== 1) begin
      bad++; $display("FAIL bp_no_accept: aw=%0d ar=%0d required 0/1", n_aw - aw0, n_ar - ar0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic [1:0] rr; int lat, aw; bit hok, to;
    issue(1, 32'h30, 32'h5A5A1234, 4'b0101, 0, rd, rr, lat, aw, hok, to);
    ref_write(32'h30, 32'h5A5A1234, 4'b0101);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_idle: rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
    issue(0, 32'h30, 32'h0, 4'h0, 0, rd, rr, lat, aw, hok, to);
    total++; if (aw !== 0) begin bad++; $display("FAIL b2b_accept_wait: got %0d required 0", aw); end
    total++; if (to || rd !== ref_read(32'h30)) begin bad++; $display("FAIL b2b_rdata: got %h required %h", rd, ref_read(32'h30)); end
  endtask

  task automatic test_reset_mid();
    logic [140:0] obs; logic [31:0] rd; logic [1:0] rr; int lat, aw, k, b0; bit hok, to;
    cfg_b_dly = 50; b0 = n_b;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
    k = 0;
    do begin @(negedge ACLK); k++; end while (!cmd_ready && k < 50);
    @(posedge ACLK); #1; cmd_valid = 0;
    k = 0;
    do begin @(negedge ACLK); k++; end while (BREADY !== 1'b1 && k < 20);
    total++; if (BREADY !== 1'b1) begin bad++; $display("FAIL rstmid_reach_wr_b: BREADY=%b required 1", BREADY); end
    #2 ARESETN = 0;
    #1;
    obs = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, AWADDR, AWVALID, WDATA, WSTRB, WVALID,
           BREADY, ARADDR, ARVALID, RREADY};
    total++; if (obs !== '0) begin bad++; $display("FAIL rstmid_outputs: got %h required 0", obs); end
    repeat (2) @(posedge ACLK);
    @(negedge ACLK); ARESETN = 1; cfg_b_dly = 0;
    @(posedge ACLK); #1;
    total++; if (n_b - b0 !== 0) begin bad++; $display("FAIL rstmid_no_b: got %0d required 0", n_b - b0); end
    issue(0, 32'h4, 32'h0, 4'h0, 0, rd, rr, lat, aw, hok, to);
    total++;
    if (to || rd !== ref_read(32'h4) || rr !== 2'b00 || lat !== 3) begin
      bad++; $display("FAIL rstmid_read: rdata=%h resp=%b lat=%0d required %h/00/3", rd, rr, lat, ref_read(32'h4));
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, exp_d; logic [3:0] s; logic [1:0] rr, exp_r;
    int lat, aw, hold, exp_lat; bit wr, hok, to;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 15)) << 2;
      d = $urandom; s = 4'($urandom_range(0, 15));
      cfg_aw_dly = $urandom_range(0, 3); cfg_w_dly = $urandom_range(0, 3); cfg_b_dly = $urandom_range(0, 3);
      cfg_ar_dly = $urandom_range(0, 3); cfg_r_dly = $urandom_range(0, 3);
      cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
      hold = $urandom_range(0, 2);
      if (wr) begin
        exp_d = 32'h0; exp_r = cfg_bresp;
        exp_lat = 3 + ((cfg_aw_dly > cfg_w_dly) ? cfg_aw_dly : cfg_w_dly) + cfg_b_dly;
      end else begin
        exp_d = ref_read(a); exp_r = cfg_rresp;
        exp_lat = 3 + cfg_ar_dly + cfg_r_dly;
      end
      issue(wr, a, d, s, hold, rd, rr, lat, aw, hok, to);
      if (wr) ref_write(a, d, s);
      total++; if (to) begin bad++; $display("FAIL rnd_timeout[%0d]: no response, required one", i); end
      total++; if (rd !== exp_d) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h required %h", i, rd, exp_d); end
      total++; if (rr !== exp_r) begin bad++; $display("FAIL rnd_resp[%0d]: got %b required %b", i, rr, exp_r); end
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d required %0d", i, lat, exp_lat); end
      if (hold > 0) begin
        total++; if (!hok) begin bad++; $display("FAIL rnd_hold[%0d]: response changed while stalled, required stable", i); end
      end
    end
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;
  endtask

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd; logic [1:0] rr; int lat, aw, c0; bit hok, to;
    mon_en = 0; cfg_ar_dly = 1000; c0 = n_arv_cyc;
    issue(0, 32'h8, 32'h0, 4'h0, 0, rd, rr, lat, aw, hok, to);
    cfg_ar_dly = 0; mon_en = 1;
    total++; if (to || rr !== 2'b11) begin bad++; $display("FAIL timeout_resp: got %b required 11", rr); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL timeout_rdata: got %h required 0", rd); end
    total++; if (n_arv_cyc - c0 !== 16) begin bad++; $display("FAIL timeout_arvalid_cycles: got %0d required 16", n_arv_cyc - c0); end
    total++; if (lat !== 17) begin bad++; $display("FAIL timeout_latency: got %0d required 17", lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_order();
    test_rsp_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite master.
- Converts a simple valid/ready command port (from a CPU-side or test sequencer) into AXI4-Lite write or read transactions on the five channels.
- Returns one response per command.
- Sits directly upstream of axi4_lite_slave and drives its AW/W/B/AR/R ports.

Parameters:
- ADDR_W, 32, address width of cmd_addr, AWADDR, ARADDR.
- DATA_W, 32, data width; WSTRB width is DATA_W/8.
- TIMEOUT_CYCLES, 256, wait limit per transaction; used only with the optional feature.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP value.
- AWADDR  out  ADDR_W.
- AWVALID  out  1.
- AWREADY  in  1.
- WDATA  out  DATA_W.
- WSTRB  out  DATA_W/8.
- WVALID  out  1.
- WREADY  in  1.
- BRESP  in  2.
- BVALID  in  1.
- BREADY  out  1.
- ARADDR  out  ADDR_W.
- ARVALID  out  1.
- ARREADY  in  1.
- RDATA  in  DATA_W.
- RRESP  in  2.
- RVALID  in  1.
- RREADY  out  1.

Behaviour:
- Reset (ARESETN low, asynchronous): state IDLE.
  - All VALID/READY outputs 0, so cmd_ready 0 during reset.
  - All address/data/resp outputs 0.
  - Operating with one clock (ACLK) only.
- All outputs are registered except cmd_ready, which equals (state == IDLE).
- States and transitions:
  - IDLE: on cmd_valid and cmd_ready, capture addr/wdata/wstrb.
    - Write: go to WR_AW_W.
    - Read: go to RD_AR.
  - WR_AW_W: AWVALID and WVALID rise together one cycle after acceptance.
    - Each channel drops independently on the edge where its own VALID and READY are both high.
    - AW and W may complete in either order or the same cycle.
    - When both are done, go to WR_B with BREADY = 1.
  - WR_B: on BVALID and BREADY, latch BRESP into rsp_resp, set rsp_rdata = 0 and BREADY = 0, go to RSP.
  - RD_AR: ARVALID = 1 until ARREADY is seen, then ARVALID = 0, RREADY = 1, go to RD_R.
  - RD_R: on RVALID and RREADY, latch RDATA/RRESP, set RREADY = 0, go to RSP.
  - RSP: rsp_valid = 1; hold rsp_rdata/rsp_resp stable until rsp_ready. On rsp_ready, rsp_valid = 0 and go to IDLE.
- AXI stability rules:
  - Address, data and strobe outputs remain constant while the corresponding VALID is high.
  - A VALID is never withdrawn before its handshake.
- Latency:
  - Minimum write, from command accept to rsp_valid, is 3 cycles (AW/W handshake in cycle 1, B in cycle 2). Minimum read is likewise 3 cycles.
  - Back-to-back commands have 1 idle cycle between responses (the RSP to IDLE transition).
- Only one transaction outstanding; cmd_ready stays low from acceptance until the response is consumed.
- BVALID or RVALID arriving in an unexpected state is ignored; BREADY and RREADY are low there.
- Reset asserted mid-transaction: everything returns immediately to reset values; the in-flight command is discarded.

Optional Feature:
- Macro: AXI4_LITE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to each wait state (WR_AW_W, WR_B, RD_AR, RD_R) and increments each cycle in that state.
  - On reaching TIMEOUT_CYCLES, all AXI VALID/READY outputs drop to 0, rsp_resp = 2'b11 (DECERR), rsp_rdata = 0, go to RSP.
- Undefined: no counter; the master waits indefinitely.

Test Plan:
- Write 0xCAFEBABE to addr 0x0; slave model asserts AWREADY and WREADY together, then BVALID with BRESP=00 -> AWVALID/WVALID seen for exactly 1 handshake; rsp_valid with rsp_resp=00, rsp_rdata=0.
- Read addr 0x0; ARREADY after 2 cycles, RVALID with RDATA=0xCAFEBABE, RRESP=00 -> ARADDR stable while waiting; rsp_rdata=0xCAFEBABE.
- Write where AWREADY arrives 3 cycles before WREADY -> AWVALID drops after its handshake, WVALID stays high until its own; exactly one B accepted.
- rsp_ready held low for 5 cycles after a read -> rsp_valid and rsp_rdata stable; cmd_ready stays 0; a second cmd_valid is not accepted until rsp_ready.
- ARESETN pulled low while in WR_B -> all outputs 0 immediately; after release, a new read to 0x4 completes normally.
- With AXI4_LITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts ARREADY -> ARVALID drops after 16 cycles; rsp_resp=11, rsp_rdata=0.
